// File: rtl/multicycle_addsub_pkg.sv
// Shared types and helpers for the multi-cycle ripple adder/subtractor.
package multicycle_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of RUN cycles needed to sweep the full operand width.
   function automatic int unsigned calc_nsteps(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

   // Step counter width; never narrower than one bit.
   function automatic int unsigned calc_step_w(input int unsigned nsteps);
      return (nsteps > 1) ? $clog2(nsteps) : 1;
   endfunction

   // One full-adder cell: returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
      return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
   endfunction

endpackage

// File: rtl/multicycle_addsub_if.sv
// Operand/result handshake bundle for multicycle_addsub.
interface multicycle_addsub_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             Cin;
   logic             Sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;

   modport master (
      output in_valid, X, Y, Cin, Sub, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf
   );

   modport slave (
      input  in_valid, X, Y, Cin, Sub, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf
   );
endinterface

// File: rtl/ripple_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
module ripple_digit
   import multicycle_addsub_pkg::*;
#(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic       w_carry;
   logic [1:0] w_fa;

   // Ripple the carry through the cells, tapping the carry into the top bit.
   always_comb begin
      s       = '0;
      c_msb   = ci;
      w_carry = ci;
      w_fa    = '0;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) c_msb = w_carry;
         w_fa    = full_add(a[i], b[i], w_carry);
         s[i]    = w_fa[0];
         w_carry = w_fa[1];
      end
      co = w_carry;
   end

endmodule

// File: rtl/multicycle_addsub.sv
// Multi-cycle add/subtract: DIGIT bits per clock with a registered carry.
module multicycle_addsub
   import multicycle_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   multicycle_addsub_if.slave  bus
);

   localparam int unsigned       NSTEPS    = calc_nsteps(WIDTH, DIGIT);
   localparam int unsigned       STEP_W    = calc_step_w(NSTEPS);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);
   localparam logic [WIDTH-1:0]  DIG_MASK  = WIDTH'({DIGIT{1'b1}});

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_carry;
   logic              r_cout;
   logic              r_ovf;
   logic [STEP_W-1:0] r_step;

   logic              w_accept;
   logic              w_run;
   logic              w_last;
   logic [31:0]       w_base;
   logic [DIGIT-1:0]  w_a_dig;
   logic [DIGIT-1:0]  w_b_dig;
   logic [DIGIT-1:0]  w_s_dig;
   logic              w_co;
   logic              w_c_msb;
   logic [WIDTH-1:0]  w_sum_nxt;

   // Select the current digit of each operand and merge the slice result into Sum.
   assign w_base    = 32'(r_step) * DIGIT;
   assign w_a_dig   = DIGIT'(r_a >> w_base);
   assign w_b_dig   = DIGIT'(r_b >> w_base);
   assign w_sum_nxt = (r_sum & ~(DIG_MASK << w_base)) | (WIDTH'(w_s_dig) << w_base);

   ripple_digit #(.DIGIT(DIGIT)) u_digit (
      .a     (w_a_dig),
      .b     (w_b_dig),
      .ci    (r_carry),
      .s     (w_s_dig),
      .co    (w_co),
      .c_msb (w_c_msb)
   );

   // Next-state and datapath enables.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_run       = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.in_valid && r_in_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_run = 1'b1;
            if (r_step == LAST_STEP) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready && r_out_valid) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register with handshake flags registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == IDLE);
         r_out_valid <= (w_state_nxt == DONE);
      end
   end

   // Operand capture, per-digit accumulation and final flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_step  <= '0;
      end else begin
         if (w_accept) begin
            r_a     <= bus.X;
            r_b     <= bus.Sub ? ~bus.Y : bus.Y;
            r_carry <= bus.Cin ^ bus.Sub;
            r_step  <= '0;
         end
         if (w_run) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_co;
            r_step  <= r_step + STEP_W'(1);
         end
         if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= w_c_msb ^ w_co;
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.Sum       = r_sum;
   assign bus.Cout      = r_cout;
   assign bus.Ovf       = r_ovf;

endmodule
